// File: rtl/avalon_multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
//  - reg_off_e : per-channel register offsets (low three address bits)
//  - CTRL_*    : bit positions inside the CONTROL register
//  - ST_*      : bit positions inside the STATUS register
//  - status_word() packs the status flags into a 16-bit read word
package avalon_multi_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_RESERVED = 3'd7
  } reg_off_e;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;
  localparam int ST_OVR = 2;

  function automatic logic [15:0] status_word(input logic ovr, input logic run, input logic to);
    logic [15:0] w;
    w         = '0;
    w[ST_OVR] = ovr;
    w[ST_RUN] = run;
    w[ST_TO]  = to;
    return w;
  endfunction

endpackage

// File: rtl/avalon_multi_timer_channel.sv
// timer_channel: one down-counting interval timer with prescaler.
// Ports:
//  clk, reset_n : clock, asynchronous active-low reset
//  i_wr         : write strobe already qualified for this channel
//  i_reg        : register offset (shared by reads and writes)
//  i_wdata      : 16-bit write data
//  o_rdata      : combinational read data for offset i_reg
//  o_irq        : TO & ITO
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 16,
  parameter int DEF_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr,
  input  logic [2:0]  i_reg,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_irq
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic [PRE_W-1:0] r_pre_cfg;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_run;
  logic             r_cont;
  logic             r_ito;
  logic             r_to;
  logic             r_ovr;

  logic             w_wr_status;
  logic             w_wr_ctrl;
  logic             w_wr_period;
  logic             w_wr_snap;
  logic             w_wr_pre;
  logic             w_tick;
  logic             w_timeout;
  logic [CNT_W-1:0] w_new_period;
  logic [15:0]      w_period_hi;
  logic [15:0]      w_snap_hi;

  assign w_wr_status = i_wr && (i_reg == REG_STATUS);
  assign w_wr_ctrl   = i_wr && (i_reg == REG_CONTROL);
  assign w_wr_period = i_wr && ((i_reg == REG_PERIOD_L) || (i_reg == REG_PERIOD_H));
  assign w_wr_snap   = i_wr && ((i_reg == REG_SNAP_L) || (i_reg == REG_SNAP_H));
  assign w_wr_pre    = i_wr && (i_reg == REG_PRESCALE);

  assign w_tick    = r_run && (r_pre_cnt == '0);
  assign w_timeout = w_tick && (r_cnt == '0);

  // Period value after this cycle's write; also the counter reload value.
  always_comb begin
    w_new_period = r_period;
    if (i_wr && (i_reg == REG_PERIOD_L)) w_new_period[15:0] = i_wdata;
    if (i_wr && (i_reg == REG_PERIOD_H)) w_new_period[CNT_W-1:16] = i_wdata[CNT_W-17:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= CNT_W'(DEF_PERIOD);
      r_period  <= CNT_W'(DEF_PERIOD);
      r_snap    <= '0;
      r_pre_cfg <= '0;
      r_pre_cnt <= '0;
      r_run     <= 1'b0;
      r_cont    <= 1'b0;
      r_ito     <= 1'b0;
      r_to      <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      // Counter / prescaler. A period write overrides any tick in flight.
      if (w_wr_period) begin
        r_period  <= w_new_period;
        r_cnt     <= w_new_period;
        r_pre_cnt <= '0;
      end else begin
        if (r_run) begin
          if (w_tick) begin
            r_pre_cnt <= r_pre_cfg;
            r_cnt     <= w_timeout ? r_period : (r_cnt - CNT_W'(1));
          end else begin
            r_pre_cnt <= r_pre_cnt - PRE_W'(1);
          end
        end
        // Writing PRESCALE also restarts the prescale phase, so the first
        // tick after START comes PRESCALE+1 clocks later.
        if (w_wr_pre) begin
          r_pre_cfg <= i_wdata[PRE_W-1:0];
          r_pre_cnt <= i_wdata[PRE_W-1:0];
        end
      end

      // RUN: period write > START > STOP > one-shot expiry.
      if (w_wr_period)                          r_run <= 1'b0;
      else if (w_wr_ctrl && i_wdata[CTRL_START]) r_run <= 1'b1;
      else if (w_wr_ctrl && i_wdata[CTRL_STOP])  r_run <= 1'b0;
      else if (w_timeout && !r_cont)            r_run <= 1'b0;

      if (w_wr_ctrl) begin
        r_ito  <= i_wdata[CTRL_ITO];
        r_cont <= i_wdata[CTRL_CONT];
      end

      // A timeout coinciding with a STATUS clear leaves TO set and OVR as is.
      if (w_timeout) begin
        r_to <= 1'b1;
        if (r_to && !w_wr_status) r_ovr <= 1'b1;
      end else if (w_wr_status) begin
        r_to  <= 1'b0;
        r_ovr <= 1'b0;
      end

      // Captures the value held before this cycle's decrement.
      if (w_wr_snap) r_snap <= r_cnt;
    end
  end

  assign w_period_hi = 16'(r_period[CNT_W-1:16]);
  assign w_snap_hi   = 16'(r_snap[CNT_W-1:16]);

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_STATUS:   o_rdata = status_word(r_ovr, r_run, r_to);
      REG_CONTROL:  o_rdata = {14'd0, r_cont, r_ito};
      REG_PERIOD_L: o_rdata = r_period[15:0];
      REG_PERIOD_H: o_rdata = w_period_hi;
      REG_SNAP_L:   o_rdata = r_snap[15:0];
      REG_SNAP_H:   o_rdata = w_snap_hi;
      REG_PRESCALE: o_rdata = 16'(r_pre_cfg);
      default:      o_rdata = '0;
    endcase
  end

  assign o_irq = r_to && r_ito;

endmodule

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CH interval timers behind a 16-bit Avalon-MM slave.
// Ports:
//  clk, reset_n : clock, asynchronous active-low reset
//  chipselect   : slave select
//  write_n      : active-low write strobe
//  address      : {channel, reg[2:0]}
//  writedata    : 16-bit write data
//  readdata     : read data, registered (latency 1)
//  irq          : OR of irq_vec
//  irq_vec      : per-channel interrupt
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 16,
  parameter int DEF_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic [15:0]               writedata,
  output logic [15:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   w_ch;
  logic              w_ch_valid;
  logic              w_wr;
  logic [NUM_CH-1:0] w_wr_vec;
  logic [15:0]       w_rd_data [NUM_CH];
  logic [15:0]       w_rd_mux;
  logic [15:0]       r_readdata;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign w_ch = address[$clog2(NUM_CH)+2:3];
    end else begin : g_single
      assign w_ch = '0;
    end
  endgenerate

  // Channel indices past NUM_CH-1 ignore writes and read back 0.
  assign w_ch_valid = (int'(w_ch) < NUM_CH);
  assign w_wr       = chipselect && !write_n && w_ch_valid;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr_vec[gi] = w_wr && (w_ch == CH_W'(gi));

      timer_channel #(
        .CNT_W      (CNT_W),
        .PRE_W      (PRE_W),
        .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (w_wr_vec[gi]),
        .i_reg   (address[2:0]),
        .i_wdata (writedata),
        .o_rdata (w_rd_data[gi]),
        .o_irq   (irq_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch_valid && (w_ch == CH_W'(i))) w_rd_mux = w_rd_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_readdata <= '0;
    else if (chipselect && write_n)  r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
module tb_avalon_multi_timer;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 32;
  localparam int PRE_W      = 16;
  localparam int DEF_PERIOD = 49999;
  localparam int AW         = $clog2(NUM_CH) + 3;

  logic              clk;
  logic              reset_n;
  logic              chipselect;
  logic              write_n;
  logic [AW-1:0]     address;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  avalon_multi_timer #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRE_W      (PRE_W),
    .DEF_PERIOD (DEF_PERIOD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  bit     model_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model. A running channel is described by the edge s at which
  // its current run segment began, the counter c0 and prescale count q0 it
  // held then; everything later is derived arithmetically from elapsed clocks.
  bit     m_run  [NUM_CH];
  bit     m_cont [NUM_CH];
  bit     m_ito  [NUM_CH];
  longint m_period [NUM_CH];
  longint m_P    [NUM_CH];
  longint m_cnt  [NUM_CH];
  longint m_pre  [NUM_CH];
  longint m_acc  [NUM_CH];
  longint m_base [NUM_CH];
  longint m_snap [NUM_CH];
  longint m_s    [NUM_CH];
  longint m_c0   [NUM_CH];
  longint m_q0   [NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_cont[i] = 0; m_ito[i] = 0;
      m_period[i] = DEF_PERIOD; m_cnt[i] = DEF_PERIOD;
      m_P[i] = 0; m_pre[i] = 0; m_acc[i] = 0; m_base[i] = 0; m_snap[i] = 0;
      m_s[i] = 0; m_c0[i] = 0; m_q0[i] = 0;
    end
  endtask

  // Edge at which a one-shot segment reaches its timeout.
  function automatic longint seg_end(int ch);
    return m_s[ch] + m_q0[ch] + 1 + m_c0[ch] * (m_P[ch] + 1);
  endfunction

  function automatic longint ticks_at(int ch, longint t);
    longint tt = t;
    longint e;
    if (!m_cont[ch] && tt > seg_end(ch)) tt = seg_end(ch);
    e = tt - m_s[ch];
    if (e < m_q0[ch] + 1) return 0;
    return 1 + (e - m_q0[ch] - 1) / (m_P[ch] + 1);
  endfunction

  function automatic bit run_at(int ch, longint t);
    if (!m_run[ch]) return 0;
    if (!m_cont[ch] && t >= seg_end(ch)) return 0;
    return 1;
  endfunction

  function automatic longint cnt_at(int ch, longint t);
    longint n;
    if (!m_run[ch]) return m_cnt[ch];
    n = ticks_at(ch, t);
    if (n <= m_c0[ch]) return m_c0[ch] - n;
    return m_period[ch] - ((n - m_c0[ch] - 1) % (m_period[ch] + 1));
  endfunction

  function automatic longint pre_at(int ch, longint t);
    longint n, e, last;
    if (!m_run[ch]) return m_pre[ch];
    if (!m_cont[ch] && t >= seg_end(ch)) return m_P[ch];
    n = ticks_at(ch, t);
    e = t - m_s[ch];
    if (n == 0) return m_q0[ch] - e;
    last = m_q0[ch] + 1 + (n - 1) * (m_P[ch] + 1);
    return m_P[ch] - (e - last);
  endfunction

  function automatic longint tos_at(int ch, longint t);
    longint n;
    if (!m_run[ch]) return m_acc[ch];
    n = ticks_at(ch, t);
    if (n <= m_c0[ch]) return m_acc[ch];
    return m_acc[ch] + 1 + (n - m_c0[ch] - 1) / (m_period[ch] + 1);
  endfunction

  // Fold the current segment up to edge t into the held state.
  task automatic freeze(int ch, longint t);
    longint c, p, a;
    bit r;
    c = cnt_at(ch, t); p = pre_at(ch, t); a = tos_at(ch, t); r = run_at(ch, t);
    m_cnt[ch] = c; m_pre[ch] = p; m_acc[ch] = a; m_run[ch] = r;
    if (r) begin m_s[ch] = t; m_c0[ch] = c; m_q0[ch] = p; end
  endtask

  task automatic model_write(int ch, int r, longint d, longint t);
    longint snapval;
    snapval = cnt_at(ch, t - 1);
    freeze(ch, t);
    case (r)
      0: m_base[ch] = m_acc[ch];
      1: begin
        m_ito[ch]  = d[0];
        m_cont[ch] = d[1];
        if (d[2]) begin
          if (!m_run[ch]) begin
            m_run[ch] = 1; m_s[ch] = t; m_c0[ch] = m_cnt[ch]; m_q0[ch] = m_pre[ch];
          end
        end else if (d[3]) m_run[ch] = 0;
      end
      2, 3: begin
        if (r == 2) m_period[ch] = (m_period[ch] & 64'hFFFF_0000) | d;
        else        m_period[ch] = (d << 16) | (m_period[ch] & 64'hFFFF);
        m_cnt[ch] = m_period[ch]; m_pre[ch] = 0; m_run[ch] = 0;
      end
      4, 5: m_snap[ch] = snapval;
      6: begin m_P[ch] = d; m_pre[ch] = d; m_q0[ch] = d; end
      default: ;
    endcase
  endtask

  function automatic longint exp_read(int ch, int r, longint t);
    longint tot = tos_at(ch, t) - m_base[ch];
    longint to_b  = (tot >= 1) ? 1 : 0;
    longint ovr_b = (tot >= 2) ? 1 : 0;
    longint run_b = run_at(ch, t) ? 1 : 0;
    case (r)
      0: return (ovr_b << 2) | (run_b << 1) | to_b;
      1: return (longint'(m_cont[ch]) << 1) | longint'(m_ito[ch]);
      2: return m_period[ch] & 64'hFFFF;
      3: return (m_period[ch] >> 16) & 64'hFFFF;
      4: return m_snap[ch] & 64'hFFFF;
      5: return (m_snap[ch] >> 16) & 64'hFFFF;
      6: return m_P[ch];
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Interrupt outputs against the model on every cycle.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_vec;
    if (model_on) begin
      for (int i = 0; i < NUM_CH; i++)
        exp_vec[i] = m_ito[i] && ((tos_at(i, cyc) - m_base[i]) >= 1);
      n_tests++;
      if (irq_vec !== exp_vec || irq !== (|exp_vec)) begin
        n_fail++;
        $display("FAIL irq_cycle %0d: irq_vec=%b irq=%b, expected irq_vec=%b irq=%b",
                 cyc, irq_vec, irq, exp_vec, |exp_vec);
      end
    end
  end

  task automatic wr(input int ch, input int r, input int d);
    longint te;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0;
    address = AW'(ch * 8 + r); writedata = 16'(d);
    te = cyc + 1;
    @(posedge clk); #1;
    model_write(ch, r, longint'(d), te);
    chipselect = 1'b0; write_n = 1'b1;
    $display("[TB] WR ch%0d reg%0d <= 0x%04h at edge %0d", ch, r, d, te);
  endtask

  task automatic rd(input int ch, input int r, output longint val, output longint expv);
    longint te;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = AW'(ch * 8 + r);
    te = cyc + 1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    expv = exp_read(ch, r, te - 1);
    @(negedge clk);
    val = longint'(readdata);
    $display("[TB] RD ch%0d reg%0d -> 0x%04h (model 0x%04h)", ch, r, val, expv);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v, e;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    model_reset();
    wait_cycles(3);
    check("rst_readdata", longint'(readdata), 0);
    check("rst_irq", longint'(irq), 0);
    check("rst_irq_vec", longint'(irq_vec), 0);
    reset_n = 1'b1;
    model_on = 1'b1;

    // Reset values visible through the bus.
    rd(0, 2, v, e); check("t1_period_l_model", v, e); check("t1_period_l", v, 64'hC34F);
    rd(0, 3, v, e); check("t1_period_h", v, 0);
    rd(0, 0, v, e); check("t1_status", v, 0);

    // Ch1: continuous, period 9, no prescale -> timeout every 10 clks.
    wr(1, 2, 9); wr(1, 3, 0); wr(1, 6, 0); wr(1, 1, 7);
    wait_cycles(10); check("t2_irq1_before", longint'(irq_vec[1]), 0);
    wait_cycles(1);  check("t2_irq1_rise", longint'(irq_vec[1]), 1);
    rd(1, 0, v, e); check("t2_status_model", v, e); check("t2_status", v, 3);
    wr(1, 0, 0);

    // Ch2: one-shot, period 3, prescale 4 -> timeout 20 clks after START.
    wr(2, 2, 3); wr(2, 6, 4); wr(2, 1, 5);
    wait_cycles(20); check("t3_irq2_before", longint'(irq_vec[2]), 0);
    wait_cycles(1);  check("t3_irq2_rise", longint'(irq_vec[2]), 1);
    rd(2, 0, v, e); check("t3_status_model", v, e); check("t3_status", v, 1);
    wait_cycles(7);
    wr(2, 4, 0);
    rd(2, 4, v, e); check("t3_snap_model", v, e); check("t3_snap_reload", v, 3);
    rd(2, 6, v, e); check("t3_prescale", v, 4);

    // Ch0: continuous, period 4, prescale 1 -> two timeouts give OVR.
    wr(0, 2, 4); wr(0, 6, 1); wr(0, 1, 7);
    wait_cycles(25);
    rd(0, 0, v, e); check("t4_status_model", v, e); check("t4_status_ovr", v, 7);
    wr(0, 0, 0);
    @(negedge clk); check("t4_irq0_drop", longint'(irq_vec[0]), 0);
    rd(0, 0, v, e); check("t4_status_clr_model", v, e); check("t4_status_clr", v, 2);

    // Ch3: START+STOP together starts; period write while running stops and reloads.
    wr(3, 2, 100); wr(3, 1, 12);
    rd(3, 0, v, e); check("t5_status_model", v, e); check("t5_start_wins", v, 2);
    wait_cycles(10);
    wr(3, 2, 50);
    rd(3, 0, v, e); check("t5_stop_model", v, e); check("t5_stopped", v, 0);
    wr(3, 4, 0);
    rd(3, 4, v, e); check("t5_reload_model", v, e); check("t5_reload", v, 50);

    // Snapshot mid-count captures the pre-decrement value (50 - 5).
    wr(3, 1, 4);
    wait_cycles(5);
    wr(3, 4, 0);
    rd(3, 4, v, e); check("t6_snap_l_model", v, e); check("t6_snap_l", v, 45);
    rd(3, 5, v, e); check("t6_snap_h", v, 0);
    wr(3, 7, 16'hFFFF);
    rd(3, 7, v, e); check("t6_reserved", v, 0);
    wr(0, 5, 0);
    rd(0, 4, v, e); check("t6_ch0_snap_l", v, e);
    rd(0, 5, v, e); check("t6_ch0_snap_h", v, e);
    rd(0, 1, v, e); check("t6_ch0_ctrl", v, 3);
    rd(1, 0, v, e); check("t6_ch1_status", v, e);

    // Asynchronous reset in the middle of a clock phase.
    @(negedge clk); #2;
    reset_n = 1'b0; model_on = 1'b0;
    #1;
    check("t7_async_irq", longint'(irq), 0);
    check("t7_async_irq_vec", longint'(irq_vec), 0);
    check("t7_async_readdata", longint'(readdata), 0);
    wait_cycles(2);
    model_reset();
    reset_n = 1'b1; model_on = 1'b1;
    rd(1, 0, v, e); check("t7_status", v, 0);
    rd(1, 2, v, e); check("t7_period_l", v, 64'hC34F);
    wait_cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
